rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 78 +++++++
 tb/tb_rf_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: two requesters (ALU = A, load = B) share one registered write port.
// Optional macro RF_WB_RR_EN selects round-robin conflict resolution; otherwise the load port always wins.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        RegWrite,
    output logic [4:0]  rc,
    output logic [31:0] dc,
    input  logic [4:0]  qa,
    output logic        qa_hit,
    output logic [15:0] conflicts
);

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic        last_grant;
    logic        conflict;
    logic        b_wins;
    logic        xfer;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;

`ifdef RF_WB_RR_EN
    assign b_wins = (last_grant == GRANT_A);
`else
    // last_grant is still tracked in this build, but only for observability.
    logic last_grant_unused;
    assign last_grant_unused = last_grant;
    assign b_wins = 1'b1;
`endif

    // Handshake: a word moves when X_valid && X_ready in the same cycle; the
    // requester keeps valid/addr/data stable until then. Ready is withheld
    // during reset and at most one ready is ever high.
    always_comb begin
        conflict  = a_valid && b_valid;
        a_ready   = !rst && a_valid && !(b_valid && b_wins);
        b_ready   = !rst && b_valid && (!a_valid || b_wins);
        xfer      = a_ready || b_ready;
        xfer_addr = b_ready ? b_addr : a_addr;
        xfer_data = b_ready ? b_data : a_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            rc         <= 5'd0;
            dc         <= 32'd0;
            conflicts  <= 16'd0;
            last_grant <= GRANT_A;
        end else begin
            // Writes to register 0 are accepted but dropped here.
            RegWrite <= xfer && (xfer_addr != 5'd0);
            if (xfer && (xfer_addr != 5'd0)) begin
                rc <= xfer_addr;
                dc <= xfer_data;
            end
            if (xfer) begin
                last_grant <= b_ready ? GRANT_B : GRANT_A;
            end
            if (conflict && (conflicts != 16'hFFFF)) begin
                conflicts <= conflicts + 16'd1;
            end
        end
    end

    assign qa_hit = RegWrite && (rc == qa) && (qa != 5'd0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single/dual requests, r0 writes,
// hazard query, mid-operation reset and conflict-counter saturation.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        RegWrite;
    logic [4:0]  rc;
    logic [31:0] dc;
    logic [4:0]  qa;
    logic        qa_hit;
    logic [15:0] conflicts;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        exp_grant_b[4];

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .RegWrite  (RegWrite),
        .rc        (rc),
        .dc        (dc),
        .qa        (qa),
        .qa_hit    (qa_hit),
        .conflicts (conflicts)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_a(input logic v, input logic [4:0] addr, input logic [31:0] data);
        a_valid = v;
        a_addr  = addr;
        a_data  = data;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] addr, input logic [31:0] data);
        b_valid = v;
        b_addr  = addr;
        b_data  = data;
    endtask

    initial begin
        logic [31:0] exp_rc;
        logic [31:0] exp_dc;
        rst = 1'b1;
        qa  = 5'd0;
        // Requests present during reset must be ignored.
        drive_a(1'b1, 5'd4, 32'h1111_1111);
        drive_b(1'b1, 5'd6, 32'h2222_2222);
        tick();
        tick();
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_rc", {27'd0, rc}, 32'd0);
        check("rst_dc", dc, 32'd0);
        check("rst_conflicts", {16'd0, conflicts}, 32'd0);

        // Single ALU write.
        rst = 1'b0;
        drive_b(1'b0, 5'd0, 32'd0);
        drive_a(1'b1, 5'd5, 32'hDEAD_BEEF);
        qa = 5'd5;
        #1;
        check("a_only_a_ready", {31'd0, a_ready}, 32'd1);
        check("a_only_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        drive_a(1'b0, 5'd0, 32'd0);
        check("a_wr_regwrite", {31'd0, RegWrite}, 32'd1);
        check("a_wr_rc", {27'd0, rc}, 32'd5);
        check("a_wr_dc", dc, 32'hDEAD_BEEF);
        check("a_wr_qa_hit", {31'd0, qa_hit}, 32'd1);
        #1;
        check("idle_ready", {30'd0, a_ready, b_ready}, 32'd0);
        tick();
        check("a_wr_done_regwrite", {31'd0, RegWrite}, 32'd0);
        check("a_wr_hold_rc", {27'd0, rc}, 32'd5);
        check("a_wr_hold_dc", dc, 32'hDEAD_BEEF);

        // Load write to r0: accepted, never written.
        drive_b(1'b1, 5'd0, 32'h0000_1234);
        #1;
        check("b_r0_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        drive_b(1'b0, 5'd0, 32'd0);
        check("b_r0_regwrite", {31'd0, RegWrite}, 32'd0);
        check("b_r0_rc", {27'd0, rc}, 32'd5);
        check("b_r0_dc", dc, 32'hDEAD_BEEF);

        // Hazard query against register 9.
        qa = 5'd9;
        drive_b(1'b1, 5'd9, 32'h0000_0099);
        #1;
        check("qa_pre_hit", {31'd0, qa_hit}, 32'd0);
        tick();
        drive_b(1'b0, 5'd0, 32'd0);
        check("qa9_hit", {31'd0, qa_hit}, 32'd1);
        check("qa9_dc", dc, 32'h0000_0099);
        tick();
        check("qa9_hit_clear", {31'd0, qa_hit}, 32'd0);
        qa = 5'd0;
        drive_a(1'b1, 5'd0, 32'h0000_00AA);
        tick();
        drive_a(1'b0, 5'd0, 32'd0);
        check("qa0_hit", {31'd0, qa_hit}, 32'd0);
        check("qa0_rc", {27'd0, rc}, 32'd9);

        // Transfer in N, reset during N+1 with both requesters asserting.
        drive_a(1'b1, 5'd11, 32'h5555_5555);
        tick();
        check("pre_rst_regwrite", {31'd0, RegWrite}, 32'd1);
        rst = 1'b1;
        drive_b(1'b1, 5'd12, 32'h6666_6666);
        #1;
        check("mid_rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        check("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("mid_rst_rc", {27'd0, rc}, 32'd0);
        check("mid_rst_dc", dc, 32'd0);
        check("mid_rst_conflicts", {16'd0, conflicts}, 32'd0);

        // Four conflict cycles straight after reset (last_grant = A).
`ifdef RF_WB_RR_EN
        exp_grant_b = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_grant_b = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b0;
        drive_a(1'b1, 5'd3, 32'hA0A0_0003);
        drive_b(1'b1, 5'd7, 32'hB0B0_0007);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("conf%0d_a_ready", k), {31'd0, a_ready}, {31'd0, !exp_grant_b[k]});
            check($sformatf("conf%0d_b_ready", k), {31'd0, b_ready}, {31'd0, exp_grant_b[k]});
            exp_q.push_back(exp_grant_b[k] ? 32'd7 : 32'd3);
            tick();
            exp_rc = exp_q.pop_front();
            exp_dc = (exp_rc == 32'd7) ? 32'hB0B0_0007 : 32'hA0A0_0003;
            check($sformatf("conf%0d_regwrite", k), {31'd0, RegWrite}, 32'd1);
            check($sformatf("conf%0d_rc", k), {27'd0, rc}, exp_rc);
            check($sformatf("conf%0d_dc", k), dc, exp_dc);
            check($sformatf("conf%0d_count", k), {16'd0, conflicts}, k + 1);
        end
        drive_b(1'b0, 5'd0, 32'd0);
        #1;
        check("after_conf_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        drive_a(1'b0, 5'd0, 32'd0);
        check("after_conf_rc", {27'd0, rc}, 32'd3);
        check("after_conf_dc", dc, 32'hA0A0_0003);
        check("after_conf_count", {16'd0, conflicts}, 32'd4);

        // Counter saturation.
        drive_a(1'b1, 5'd3, 32'hA0A0_0003);
        drive_b(1'b1, 5'd7, 32'hB0B0_0007);
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        check("sat_count", {16'd0, conflicts}, 32'h0000_FFFF);
        tick();
        check("sat_hold_count", {16'd0, conflicts}, 32'h0000_FFFF);
        check("sat_one_ready", {30'd0, a_ready, b_ready} == 32'd0 ? 32'd0 : 32'd1, 32'd1);
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
